// File: rtl/mem_arbiter_pkg.sv
//==============================================================================
// Module   : mem_arbiter_pkg
// Purpose  : Shared types and constants for the unified-memory arbiter:
//            FSM state encoding, owner encoding and a small owner helper.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package mem_arbiter_pkg;

   localparam int MA_STATE_WIDTH = 3;
   localparam int MA_CNT_W       = 3;

   typedef enum logic [MA_STATE_WIDTH-1:0] {
      MA_STATE_IDLE  = 3'd0,
      MA_STATE_ISSUE = 3'd1,
      MA_STATE_WAIT  = 3'd2,
      MA_STATE_CAPT  = 3'd3,
      MA_STATE_DONE  = 3'd4
   } ma_state_t;

   localparam logic MA_OWNER_CPU = 1'b0;
   localparam logic MA_OWNER_DBG = 1'b1;

   // The port that did not hold the previous grant
   function automatic logic ma_other(input logic owner);
      return (owner == MA_OWNER_CPU) ? MA_OWNER_DBG : MA_OWNER_CPU;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
//==============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundles the CPU port, debug port and memory-side bus of the
//            unified-memory arbiter. slave = arbiter view, master = system view.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // CPU controller port
   logic              cpu_req_i;
   logic              cpu_we_i;
   logic [ADDR_W-1:0] cpu_addr_i;
   logic [DATA_W-1:0] cpu_wdata_i;
   logic [DATA_W-1:0] cpu_rdata_o;
   logic              cpu_done_o;
   logic              cpu_stall_o;
   // Debug / program-loader port
   logic              dbg_req_i;
   logic              dbg_we_i;
   logic [ADDR_W-1:0] dbg_addr_i;
   logic [DATA_W-1:0] dbg_wdata_i;
   logic [DATA_W-1:0] dbg_rdata_o;
   logic              dbg_done_o;
   // Memory side
   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [DATA_W-1:0] mem_wdata_o;
   logic [DATA_W-1:0] mem_rdata_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      input  mem_rdata_i,
      output cpu_rdata_o, cpu_done_o, cpu_stall_o,
      output dbg_rdata_o, dbg_done_o,
      output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
      output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
      output mem_rdata_i,
      input  cpu_rdata_o, cpu_done_o, cpu_stall_o,
      input  dbg_rdata_o, dbg_done_o,
      input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
   );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter_rr_arbiter2.sv
//==============================================================================
// Module   : rr_arbiter2
// Purpose  : Two-request round-robin pick. i_req[0]=CPU, i_req[1]=DBG.
//            A tie goes to the port that did not win last. When i_lock is
//            set and the last owner was DBG, the CPU is never picked.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module rr_arbiter2
   import mem_arbiter_pkg::*;
(
   input  wire logic [1:0] i_req,
   input  wire logic       i_last,
   input  wire logic       i_lock,
   output logic            o_valid,
   output logic            o_grant
);

   // Combinational grant selection
   always_comb begin
      o_valid = 1'b0;
      o_grant = MA_OWNER_CPU;
      if (i_lock && (i_last == MA_OWNER_DBG)) begin
         // Debug burst in progress: only debug may be served
         o_valid = i_req[1];
         o_grant = MA_OWNER_DBG;
      end else if (i_req[0] && i_req[1]) begin
         o_valid = 1'b1;
         o_grant = ma_other(i_last);
      end else if (i_req[0]) begin
         o_valid = 1'b1;
         o_grant = MA_OWNER_CPU;
      end else if (i_req[1]) begin
         o_valid = 1'b1;
         o_grant = MA_OWNER_DBG;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
//==============================================================================
// Module   : mem_arbiter
// Purpose  : Serialises CPU-controller and debug-port accesses to the single
//            unified memory, one transaction at a time. A granted request is
//            registered, issued for one cycle, its read data captured MEM_LAT
//            cycles later and a one-cycle done pulse returned to the owner.
// Options  : MEM_ARB_LOCK_EN - adds dbg_lock_i, which keeps the memory with
//            the debug port for back-to-back bursts.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 1
)(
   input  wire logic    clk,
   input  wire logic    rst_n,
   mem_arbiter_if.slave bus,
`ifdef MEM_ARB_LOCK_EN
   input  wire logic    dbg_lock_i,
`endif
   output logic         busy_o,
   output logic         owner_o
);

   if ((MEM_LAT < 1) || (MEM_LAT > 4)) begin : g_bad_mem_lat
      $error("mem_arbiter: MEM_LAT must be in 1..4");
   end

   // Last WAIT-cycle count; the counter is loaded with 1 on leaving ISSUE
   localparam logic [MA_CNT_W-1:0] c_last_wait = MA_CNT_W'(MEM_LAT - 1);

   ma_state_t           r_state;
   ma_state_t           w_next;
   logic [MA_CNT_W-1:0] r_cnt;
   logic                r_owner;
   logic                r_last;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_cpu_rdata;
   logic [DATA_W-1:0]   r_dbg_rdata;
   logic                w_gnt_valid;
   logic                w_gnt;
   logic                w_lock;
   logic                w_done;
   logic                w_cpu_done;

`ifdef MEM_ARB_LOCK_EN
   assign w_lock = dbg_lock_i;
`else
   assign w_lock = 1'b0;
`endif

   rr_arbiter2 u_rr (
      .i_req   ({bus.dbg_req_i, bus.cpu_req_i}),
      .i_last  (r_last),
      .i_lock  (w_lock),
      .o_valid (w_gnt_valid),
      .o_grant (w_gnt)
   );

   // State register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= MA_STATE_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         MA_STATE_IDLE:  if (w_gnt_valid) w_next = MA_STATE_ISSUE;
         MA_STATE_ISSUE: w_next = (MEM_LAT > 1) ? MA_STATE_WAIT : MA_STATE_CAPT;
         MA_STATE_WAIT:  if (r_cnt == c_last_wait) w_next = MA_STATE_CAPT;
         MA_STATE_CAPT:  w_next = MA_STATE_DONE;
         MA_STATE_DONE:  w_next = MA_STATE_IDLE;
         default:        w_next = MA_STATE_IDLE;
      endcase
   end

   // Grant latch, latency counter, read-data capture and round-robin history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_owner     <= MA_OWNER_CPU;
         r_last      <= MA_OWNER_DBG;   // CPU wins the first tie
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cpu_rdata <= '0;
         r_dbg_rdata <= '0;
      end else begin
         unique case (r_state)
            MA_STATE_IDLE: begin
               if (w_gnt_valid) begin
                  r_owner <= w_gnt;
                  r_we    <= (w_gnt == MA_OWNER_DBG) ? bus.dbg_we_i    : bus.cpu_we_i;
                  r_addr  <= (w_gnt == MA_OWNER_DBG) ? bus.dbg_addr_i  : bus.cpu_addr_i;
                  r_wdata <= (w_gnt == MA_OWNER_DBG) ? bus.dbg_wdata_i : bus.cpu_wdata_i;
               end
            end
            MA_STATE_ISSUE: r_cnt <= MA_CNT_W'(1);
            MA_STATE_WAIT:  if (r_cnt != c_last_wait) r_cnt <= r_cnt + 1'b1;
            MA_STATE_CAPT: begin
               if (!r_we) begin
                  if (r_owner == MA_OWNER_DBG) r_dbg_rdata <= bus.mem_rdata_i;
                  else                         r_cpu_rdata <= bus.mem_rdata_i;
               end
            end
            MA_STATE_DONE:  r_last <= r_owner;
            default: ;
         endcase
      end
   end

   assign w_done     = (r_state == MA_STATE_DONE);
   assign w_cpu_done = w_done && (r_owner == MA_OWNER_CPU);

   assign bus.mem_en_o    = (r_state == MA_STATE_ISSUE);
   assign bus.mem_we_o    = (r_state == MA_STATE_ISSUE) && r_we;
   assign bus.mem_addr_o  = r_addr;
   assign bus.mem_wdata_o = r_wdata;

   assign bus.cpu_rdata_o = r_cpu_rdata;
   assign bus.cpu_done_o  = w_cpu_done;
   // Gated by rst_n so every output reads 0 while reset is held
   assign bus.cpu_stall_o = rst_n && bus.cpu_req_i && !w_cpu_done;
   assign bus.dbg_rdata_o = r_dbg_rdata;
   assign bus.dbg_done_o  = w_done && (r_owner == MA_OWNER_DBG);

   assign busy_o  = (r_state != MA_STATE_IDLE);
   assign owner_o = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
//==============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter with a latency-accurate
//            memory responder and a transaction-level reference model.
// Options  : MEM_ARB_LOCK_EN - also exercises the debug lock.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_arbiter;

   localparam int LAT = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic owner;
   bit   lock_now = 1'b0;

   int checks = 0;
   int errors = 0;

   // Reference model: memory image, round-robin history, held read data
   logic [31:0] ref_mem [16];
   bit          m_last;
   logic [31:0] m_cpu_rd;
   logic [31:0] m_dbg_rd;

   // Memory contents as seen by the responder (fed only from DUT outputs)
   logic [31:0] dev_mem [16];

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
`ifdef MEM_ARB_LOCK_EN
      .dbg_lock_i (lock_now),
`endif
      .busy_o     (busy),
      .owner_o    (owner)
   );

   always #5 clk = ~clk;

   // Memory responder: data valid exactly LAT cycles after the strobe cycle
   initial begin : p_memory
      int       rem;
      bit       pend;
      bit [3:0] pidx;
      rem  = 0;
      pend = 1'b0;
      pidx = '0;
      for (int i = 0; i < 16; i++) dev_mem[i] = 32'h0;
      bus.mem_rdata_i = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (rem > 0) rem--;
         if (pend && rem == 0) begin
            bus.mem_rdata_i = dev_mem[pidx];
            pend = 1'b0;
         end else begin
            bus.mem_rdata_i = $urandom;
         end
         if (bus.mem_en_o === 1'b1) begin
            pidx = bus.mem_addr_o[5:2];
            if (bus.mem_we_o === 1'b1) dev_mem[pidx] = bus.mem_wdata_o;
            else begin
               pend = 1'b1;
               rem  = LAT;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One transaction starting in the current IDLE cycle (inputs already
   // driven). Optionally raises the other port's request at cycle raise_cyc.
   // Ends in the following IDLE cycle, dropping the winner's req unless keep.
   task automatic txn(input int raise_cyc, input bit raise_dbg, input bit keep);
      bit          win;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd_exp;
      #1;
      if (lock_now && m_last)                    win = 1'b1;
      else if (bus.cpu_req_i && bus.dbg_req_i)   win = ~m_last;
      else                                       win = bus.dbg_req_i;
      we   = win ? bus.dbg_we_i    : bus.cpu_we_i;
      addr = win ? bus.dbg_addr_i  : bus.cpu_addr_i;
      wd   = win ? bus.dbg_wdata_i : bus.cpu_wdata_i;
      rd_exp = ref_mem[addr[5:2]];
      if (we) ref_mem[addr[5:2]] = wd;
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_en", bus.mem_en_o, 1'b0);
      chk1("idle_stall", bus.cpu_stall_o, bus.cpu_req_i);
      for (int c = 1; c <= LAT + 2; c++) begin
         tick();
         if (c == raise_cyc) begin
            if (raise_dbg) bus.dbg_req_i = 1'b1;
            else           bus.cpu_req_i = 1'b1;
         end
         if (c == 1) begin
            // Requester changes after the grant must not reach the memory
            if (win) begin
               bus.dbg_we_i = $urandom; bus.dbg_addr_i = $urandom; bus.dbg_wdata_i = $urandom;
            end else begin
               bus.cpu_we_i = $urandom; bus.cpu_addr_i = $urandom; bus.cpu_wdata_i = $urandom;
            end
         end
         #1;
         chk1("mem_en", bus.mem_en_o, (c == 1));
         if (c == 1) begin
            chk1("mem_we", bus.mem_we_o, we);
            chk("mem_addr", bus.mem_addr_o, addr);
            if (we) chk("mem_wdata", bus.mem_wdata_o, wd);
            chk1("owner", owner, win);
         end
         chk1("busy", busy, 1'b1);
         chk1("cpu_done", bus.cpu_done_o, (c == LAT + 2) && !win);
         chk1("dbg_done", bus.dbg_done_o, (c == LAT + 2) && win);
         chk1("cpu_stall", bus.cpu_stall_o, bus.cpu_req_i && !((c == LAT + 2) && !win));
         if (c == LAT + 2) begin
            if (!we) begin
               if (win) m_dbg_rd = rd_exp;
               else     m_cpu_rd = rd_exp;
            end
            chk("cpu_rdata", bus.cpu_rdata_o, m_cpu_rd);
            chk("dbg_rdata", bus.dbg_rdata_o, m_dbg_rd);
         end
      end
      m_last = win;
      tick();
      if (!keep) begin
         if (win) bus.dbg_req_i = 1'b0;
         else     bus.cpu_req_i = 1'b0;
      end
   endtask

   task automatic set_cpu(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.cpu_we_i = we; bus.cpu_addr_i = addr; bus.cpu_wdata_i = wd;
   endtask

   task automatic set_dbg(input logic we, input logic [31:0] addr, input logic [31:0] wd);
      bus.dbg_we_i = we; bus.dbg_addr_i = addr; bus.dbg_wdata_i = wd;
   endtask

   initial begin : p_main
      int  mode;
      logic [1:0] seq_exp [4];
      for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
      m_last   = 1'b1;
      m_cpu_rd = 32'h0;
      m_dbg_rd = 32'h0;

      // Reset held with both requests active
      bus.cpu_req_i = 1'b1; bus.dbg_req_i = 1'b1;
      set_cpu(1'b0, 32'h0000_0040, 32'h1111_1111);
      set_dbg(1'b0, 32'h0000_0044, 32'h2222_2222);
      repeat (3) @(posedge clk);
      #2;
      chk1("rst_en", bus.mem_en_o, 1'b0);
      chk1("rst_we", bus.mem_we_o, 1'b0);
      chk("rst_addr", bus.mem_addr_o, 32'h0);
      chk("rst_wdata", bus.mem_wdata_o, 32'h0);
      chk("rst_cpu_rdata", bus.cpu_rdata_o, 32'h0);
      chk("rst_dbg_rdata", bus.dbg_rdata_o, 32'h0);
      chk1("rst_cpu_done", bus.cpu_done_o, 1'b0);
      chk1("rst_dbg_done", bus.dbg_done_o, 1'b0);
      chk1("rst_stall", bus.cpu_stall_o, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      txn(-1, 1'b0, 1'b0);
      chk1("first_grant_cpu", owner, 1'b0);
      txn(-1, 1'b0, 1'b0);
      chk1("second_grant_dbg", owner, 1'b1);

      // DBG preloads 0x10, then CPU reads it back
      set_dbg(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
      bus.dbg_req_i = 1'b1;
      txn(-1, 1'b0, 1'b0);
      set_cpu(1'b0, 32'h0000_0010, 32'h0);
      bus.cpu_req_i = 1'b1;
      txn(-1, 1'b0, 1'b0);
      chk("cpu_read_0x10", bus.cpu_rdata_o, 32'hDEAD_BEEF);
      set_dbg(1'b0, 32'h0000_0010, 32'h0);
      bus.dbg_req_i = 1'b1;
      txn(-1, 1'b0, 1'b0);
      chk("dbg_read_0x10", bus.dbg_rdata_o, 32'hDEAD_BEEF);

      // Both requests held across four grants: strict alternation
      seq_exp[0] = 2'd0; seq_exp[1] = 2'd1; seq_exp[2] = 2'd0; seq_exp[3] = 2'd1;
      set_cpu(1'b0, 32'h0000_0080, 32'h0);
      set_dbg(1'b0, 32'h0000_0084, 32'h0);
      bus.cpu_req_i = 1'b1; bus.dbg_req_i = 1'b1;
      for (int g = 0; g < 4; g++) begin
         txn(-1, 1'b0, 1'b1);
         chk1("rr_order", owner, seq_exp[g][0]);
      end
      bus.cpu_req_i = 1'b0; bus.dbg_req_i = 1'b0;

      // DBG write arrives while the CPU read is in WAIT
      set_cpu(1'b0, 32'h0000_0010, 32'h0);
      set_dbg(1'b1, 32'h0000_0020, 32'h0000_0055);
      bus.cpu_req_i = 1'b1;
      txn(2, 1'b1, 1'b0);
      chk1("late_dbg_not_done_yet", bus.dbg_done_o, 1'b0);
      txn(-1, 1'b0, 1'b0);
      chk1("late_dbg_owner", owner, 1'b1);

      // Reset asserted during WAIT aborts the access
      set_cpu(1'b0, 32'h0000_0024, 32'h0);
      bus.cpu_req_i = 1'b1;
      tick();
      #1;
      chk1("abort_issue_en", bus.mem_en_o, 1'b1);
      tick();
      rst_n = 1'b0;
      #1;
      chk1("abort_en", bus.mem_en_o, 1'b0);
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_cpu_done", bus.cpu_done_o, 1'b0);
      chk1("abort_stall", bus.cpu_stall_o, 1'b0);
      bus.cpu_req_i = 1'b0;
      repeat (2) begin
         tick();
         #1;
         chk1("abort_no_done", bus.cpu_done_o, 1'b0);
         chk1("abort_no_en", bus.mem_en_o, 1'b0);
      end
      chk("abort_cpu_rdata", bus.cpu_rdata_o, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      m_last = 1'b1; m_cpu_rd = 32'h0; m_dbg_rd = 32'h0;
      tick();
      set_cpu(1'b0, 32'h0000_0020, 32'h0);
      bus.cpu_req_i = 1'b1;
      txn(-1, 1'b0, 1'b0);
      chk("restart_read_0x20", bus.cpu_rdata_o, 32'h0000_0055);

`ifdef MEM_ARB_LOCK_EN
      // Debug lock: three DBG accesses back-to-back, CPU after release
      lock_now = 1'b1;
      set_cpu(1'b0, 32'h0000_0030, 32'h0);
      set_dbg(1'b1, 32'h0000_0034, 32'h0000_0077);
      bus.cpu_req_i = 1'b1; bus.dbg_req_i = 1'b1;
      for (int g = 0; g < 3; g++) begin
         txn(-1, 1'b0, 1'b1);
         chk1("lock_dbg_owner", owner, 1'b1);
      end
      lock_now = 1'b0;
      txn(-1, 1'b0, 1'b1);
      chk1("unlock_cpu_owner", owner, 1'b0);
      bus.cpu_req_i = 1'b0; bus.dbg_req_i = 1'b0;
`endif

      // Randomised traffic against the reference model
      for (int n = 0; n < 40; n++) begin
         set_cpu($urandom, $urandom, $urandom);
         set_dbg($urandom, $urandom, $urandom);
         mode = $urandom_range(0, 4);
         bus.cpu_req_i = (mode == 0 || mode == 2 || mode == 3);
         bus.dbg_req_i = (mode == 1 || mode == 2 || mode == 4);
         if (mode == 3)      txn($urandom_range(1, LAT + 2), 1'b1, $urandom);
         else if (mode == 4) txn($urandom_range(1, LAT + 2), 1'b0, $urandom);
         else                txn(-1, 1'b0, $urandom);
      end
      bus.cpu_req_i = 1'b0; bus.dbg_req_i = 1'b0;
      tick();
      #1;
      chk1("final_busy", busy, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
